// File: rtl/mii_rx_checker.sv
// ----------------------------------------------------------------------------
// mii_rx_checker
//
// Receive-side traffic checker for a multi-lane MII-style interface. It tracks
// frame state (IDLE / RECEIVE / ERROR) and keeps saturating statistics
// counters for accepted data and control lanes, error cycles, pattern
// mismatches and good/bad frames.
//
// Optional feature: define MII_CHK_PATTERN_EN to compile in the per-lane
// pattern comparison. Without it, mismatch_count is held at 0.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   rx_data          receive octets, lane i = rx_data[8i+7:8i]
//   rx_ctrl          per-lane flag, 1 = control character, 0 = data character
//   rx_dv            data valid, frame active while high
//   rx_er            receive error for the current cycle
//   clear            synchronous clear of all counters (state is untouched)
//   data_char_count  accepted data lanes
//   ctrl_char_count  accepted control lanes
//   error_count      cycles with rx_dv=1 and rx_er=1
//   mismatch_count   accepted lanes whose octet differs from its pattern
//   frame_ok_count   frames that ended from RECEIVE
//   frame_bad_count  frames that ended from ERROR
//   state            0 = IDLE, 1 = RECEIVE, 2 = ERROR
// ----------------------------------------------------------------------------
module mii_rx_checker #(
    parameter int         DATA_WIDTH        = 64,
    parameter int         CNT_WIDTH         = 32,
    parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
    parameter logic [7:0] CTRL_CHAR_PATTERN = 8'h55
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic [DATA_WIDTH/8-1:0] rx_ctrl,
    input  logic                    rx_dv,
    input  logic                    rx_er,
    input  logic                    clear,
    output logic [CNT_WIDTH-1:0]    data_char_count,
    output logic [CNT_WIDTH-1:0]    ctrl_char_count,
    output logic [CNT_WIDTH-1:0]    error_count,
    output logic [CNT_WIDTH-1:0]    mismatch_count,
    output logic [CNT_WIDTH-1:0]    frame_ok_count,
    output logic [CNT_WIDTH-1:0]    frame_bad_count,
    output logic [1:0]              state
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int INC_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    state_t cur_state;
    assign state = cur_state;

    // Adds a per-cycle increment and clamps at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] a,
        input logic [INC_W-1:0]     b
    );
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH + 1)'(b);
        return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
    endfunction

    // Lanes count only in clean, valid cycles outside an errored frame.
    logic accept;
    logic err_evt;
    logic frame_ok_evt;
    logic frame_bad_evt;

    assign accept        = rx_dv && !rx_er && (cur_state != ST_ERROR);
    assign err_evt       = rx_dv && rx_er;
    assign frame_ok_evt  = (cur_state == ST_RECEIVE) && !rx_dv;
    assign frame_bad_evt = (cur_state == ST_ERROR) && !rx_dv;

    logic [INC_W-1:0] data_inc;
    logic [INC_W-1:0] ctrl_inc;

    // NOTE: every variable in an always_comb gets a default first, otherwise
    // paths that skip the assignment infer a latch.
    always_comb begin
        data_inc = '0;
        ctrl_inc = '0;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (rx_ctrl[i]) ctrl_inc = ctrl_inc + INC_W'(1);
                else            data_inc = data_inc + INC_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state       <= ST_IDLE;
            data_char_count <= '0;
            ctrl_char_count <= '0;
            error_count     <= '0;
            frame_ok_count  <= '0;
            frame_bad_count <= '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (rx_dv) cur_state <= rx_er ? ST_ERROR : ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    if (!rx_dv)     cur_state <= ST_IDLE;
                    else if (rx_er) cur_state <= ST_ERROR;
                end
                ST_ERROR: begin
                    if (!rx_dv) cur_state <= ST_IDLE;
                end
                default: cur_state <= ST_IDLE;
            endcase

            // clear wins: same-cycle events are dropped, not deferred.
            if (clear) begin
                data_char_count <= '0;
                ctrl_char_count <= '0;
                error_count     <= '0;
                frame_ok_count  <= '0;
                frame_bad_count <= '0;
            end else begin
                data_char_count <= sat_add(data_char_count, data_inc);
                ctrl_char_count <= sat_add(ctrl_char_count, ctrl_inc);
                error_count     <= sat_add(error_count, INC_W'(err_evt));
                frame_ok_count  <= sat_add(frame_ok_count, INC_W'(frame_ok_evt));
                frame_bad_count <= sat_add(frame_bad_count, INC_W'(frame_bad_evt));
            end
        end
    end

`ifdef MII_CHK_PATTERN_EN
    logic [INC_W-1:0] mis_inc;

    always_comb begin
        mis_inc = '0;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                if (rx_data[8*i +: 8] != (rx_ctrl[i] ? CTRL_CHAR_PATTERN : DATA_CHAR_PATTERN))
                    mis_inc = mis_inc + INC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     mismatch_count <= '0;
        else if (clear) mismatch_count <= '0;
        else            mismatch_count <= sat_add(mismatch_count, mis_inc);
    end
`else
    // rx_data and the patterns only feed the comparison; fold them into a
    // sink so the stripped build leaves nothing dangling.
    logic unused_pattern_inputs;
    assign unused_pattern_inputs = ^{rx_data, DATA_CHAR_PATTERN, CTRL_CHAR_PATTERN};
    assign mismatch_count        = '0;
`endif

endmodule

// File: tb/tb_mii_rx_checker.sv
// ----------------------------------------------------------------------------
// tb_mii_rx_checker
//
// Directed bench for mii_rx_checker (DATA_WIDTH=64, CNT_WIDTH=8). The driver
// applies one vector per cycle and pushes the hand-computed output snapshot
// expected after the coming edge; a monitor pops and compares on the falling
// edge. Reset expectations are tagged -1 and compared just after rst_n falls.
// ----------------------------------------------------------------------------
module tb_mii_rx_checker;

    localparam int DW = 64;
    localparam int CW = 8;
`ifdef MII_CHK_PATTERN_EN
    localparam int PAT = 1;
`else
    localparam int PAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   rx_data = '0;
    logic [DW/8-1:0] rx_ctrl = '0;
    logic            rx_dv = 1'b0;
    logic            rx_er = 1'b0;
    logic            clear = 1'b0;
    logic [CW-1:0]   data_char_count, ctrl_char_count, error_count;
    logic [CW-1:0]   mismatch_count, frame_ok_count, frame_bad_count;
    logic [1:0]      state;

    mii_rx_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_ctrl         (rx_ctrl),
        .rx_dv           (rx_dv),
        .rx_er           (rx_er),
        .clear           (clear),
        .data_char_count (data_char_count),
        .ctrl_char_count (ctrl_char_count),
        .error_count     (error_count),
        .mismatch_count  (mismatch_count),
        .frame_ok_count  (frame_ok_count),
        .frame_bad_count (frame_bad_count),
        .state           (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int st;
        int dc;
        int cc;
        int ec;
        int mc;
        int ok;
        int bad;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    edge_cnt = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    logic [DW-1:0] d_all_aa  = {8{8'hAA}};
    logic [DW-1:0] d_all_55  = {8{8'h55}};
    logic [DW-1:0] d_mixed   = 64'h00AA_AAAA_5555_5555;
    logic [DW-1:0] d_top3_55 = 64'h5555_55AA_AAAA_AAAA;

    task automatic check(input exp_t e, input string nm);
        n_checks++;
        if (int'(state) != e.st || int'(data_char_count) != e.dc ||
            int'(ctrl_char_count) != e.cc || int'(error_count) != e.ec ||
            int'(mismatch_count) != e.mc || int'(frame_ok_count) != e.ok ||
            int'(frame_bad_count) != e.bad) begin
            n_errors++;
            $display("FAIL %s: got st=%0d dc=%0d cc=%0d ec=%0d mc=%0d ok=%0d bad=%0d, expected st=%0d dc=%0d cc=%0d ec=%0d mc=%0d ok=%0d bad=%0d",
                     nm, state, data_char_count, ctrl_char_count, error_count,
                     mismatch_count, frame_ok_count, frame_bad_count,
                     e.st, e.dc, e.cc, e.ec, e.mc, e.ok, e.bad);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (exp_q.size() > 0 && exp_q[0].tag >= 0 && exp_q[0].tag <= edge_cnt) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.tag < edge_cnt) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: expectation for edge %0d not compared, now at edge %0d",
                         nm, e.tag, edge_cnt);
            end else begin
                check(e, nm);
            end
        end
    end

    always @(negedge rst_n) begin
        exp_t  e;
        string nm;
        #1;
        if (exp_q.size() > 0 && exp_q[0].tag == -1) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(e, nm);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic dv, input logic er, input logic [7:0] ctrl,
                         input logic [DW-1:0] data, input logic clr);
        rx_dv   = dv;
        rx_er   = er;
        rx_ctrl = ctrl;
        rx_data = data;
        clear   = clr;
    endtask

    // tag_now=1 marks an asynchronous (reset) expectation.
    task automatic exp_push(input string nm, input bit tag_now, input int st,
                            input int dc, input int cc, input int ec, input int mc,
                            input int ok, input int bad);
        exp_t e;
        e.tag = tag_now ? -1 : edge_cnt + 1;
        e.st  = st;
        e.dc  = dc;
        e.cc  = cc;
        e.ec  = ec;
        e.mc  = mc;
        e.ok  = ok;
        e.bad = bad;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with traffic present: outputs must stay at zero / IDLE.
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("reset_hold_0", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        exp_push("reset_hold_1", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 8'h00, '0, 0);
        exp_push("after_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Ten all-data cycles then end of frame.
        for (int k = 1; k <= 10; k++) begin
            drive(1, 0, 8'h00, d_all_aa, 0);
            exp_push($sformatf("data_frame_c%0d", k), 0, 1, 8 * k, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 8'h00, '0, 0);
        exp_push("data_frame_end", 0, 0, 80, 0, 0, 0, 1, 0);
        tick();

        // Mixed lanes: 4 control at 55, 4 data at AA except lane 7 = 00.
        drive(1, 0, 8'h0F, d_mixed, 0);
        exp_push("mixed_lanes", 0, 1, 84, 4, 0, PAT, 1, 0);
        tick();
        drive(0, 0, 8'h00, '0, 0);
        exp_push("mixed_frame_end", 0, 0, 84, 4, 0, PAT, 2, 0);
        tick();

        // Errored frame: IDLE, RECEIVE, ERROR, ERROR, IDLE.
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("err_frame_c1", 0, 1, 92, 4, 0, PAT, 2, 0);
        tick();
        drive(1, 1, 8'h00, d_all_aa, 0);
        exp_push("err_frame_c2", 0, 2, 92, 4, 1, PAT, 2, 0);
        tick();
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("err_frame_c3_ignored", 0, 2, 92, 4, 1, PAT, 2, 0);
        tick();
        drive(0, 0, 8'h00, '0, 0);
        exp_push("err_frame_end", 0, 0, 92, 4, 1, PAT, 2, 1);
        tick();

        // Error straight from IDLE; rx_er ignored once rx_dv drops.
        drive(1, 1, 8'hFF, d_all_55, 0);
        exp_push("idle_to_error", 0, 2, 92, 4, 2, PAT, 2, 1);
        tick();
        drive(0, 1, 8'hFF, '0, 0);
        exp_push("error_end_dv_low_er_high", 0, 0, 92, 4, 2, PAT, 2, 2);
        tick();

        // Clear while idle.
        drive(0, 0, 8'h00, '0, 1);
        exp_push("clear_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Clear collides with accepted control cycle and with frame end.
        drive(1, 0, 8'hFF, d_all_55, 0);
        exp_push("ctrl_cycle", 0, 1, 0, 8, 0, 0, 0, 0);
        tick();
        drive(1, 0, 8'hFF, d_all_55, 1);
        exp_push("clear_vs_ctrl_cycle", 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 8'h00, '0, 1);
        exp_push("clear_vs_frame_end", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Saturation: reach 253 data lanes, then one more all-data cycle.
        for (int k = 1; k <= 31; k++) begin
            drive(1, 0, 8'h00, d_all_aa, 0);
            exp_push($sformatf("sat_fill_c%0d", k), 0, 1, 8 * k, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 8'hE0, d_top3_55, 0);
        exp_push("sat_253", 0, 1, 253, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("sat_clamp_255", 0, 1, 255, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("sat_hold_255", 0, 1, 255, 3, 0, 0, 0, 0);
        tick();
        drive(0, 0, 8'h00, '0, 0);
        exp_push("sat_frame_end", 0, 0, 255, 3, 0, 0, 1, 0);
        tick();

        // Reset pulse in the middle of a frame, away from any edge.
        drive(0, 0, 8'h00, '0, 1);
        exp_push("clear_before_pulse", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 8'h00, d_all_aa, 0);
        exp_push("pulse_frame_c1", 0, 1, 8, 0, 0, 0, 0, 0);
        tick();
        #1;
        exp_push("async_reset_pulse", 1, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        exp_push("restart_from_idle", 0, 1, 8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 8'h00, '0, 0);
        exp_push("restart_frame_end", 0, 0, 8, 0, 0, 0, 1, 0);
        tick();

        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
